// File: rtl/oci_dct_pkg.sv
// ============================================================================
// Module   : oci_dct_pkg
// Summary  : Shared sizes and FSM state encoding for the DCT sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package oci_dct_pkg;

  localparam int ENTRY_W = 3;
  localparam int ENTRIES = 10;
  localparam int BUF_W   = ENTRY_W * ENTRIES;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ENDED = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/oci_dct_packer.sv
// ============================================================================
// Module   : oci_dct_packer
// Summary  : Assembly register collecting trace entry codes into packet slots.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module oci_dct_packer #(
  parameter int  ENTRY_W = oci_dct_pkg::ENTRY_W,
  parameter int  ENTRIES = oci_dct_pkg::ENTRIES,
  localparam int BUF_W   = ENTRY_W * ENTRIES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_i,
  input  logic                         take_i,
  input  logic [ENTRY_W-1:0]           code_i,
  output logic [BUF_W-1:0]             buf_o,
  output logic [oci_dct_pkg::CNT_W-1:0] cnt_o,
  output logic                         full_o
);

  logic [BUF_W-1:0]              buf_q, buf_d;
  logic [oci_dct_pkg::CNT_W-1:0] cnt_q, cnt_d;

  // A take empties the assembly first, so a same-edge write lands in slot 0.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (take_i) begin
      buf_d = '0;
      cnt_d = '0;
    end
    if (wr_i) begin
      buf_d[ENTRY_W*cnt_d +: ENTRY_W] = code_i;
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign buf_o  = buf_q;
  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == oci_dct_pkg::CNT_W'(ENTRIES));

endmodule

`default_nettype wire

// File: rtl/oci_dct_sequencer.sv
// ============================================================================
// Module   : oci_dct_sequencer
// Summary  : Packs direct-capture trace entries into packets with a
//            valid/ready output handshake and end-of-test draining.
// Config   : OCI_DCT_DROP_CNT_EN adds the saturating dropped_cnt output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module oci_dct_sequencer #(
  parameter int  ENTRY_W = oci_dct_pkg::ENTRY_W,
  parameter int  ENTRIES = oci_dct_pkg::ENTRIES,
  localparam int BUF_W   = ENTRY_W * ENTRIES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               te_valid,
  input  logic [ENTRY_W-1:0] te_code,
  input  logic               test_ending,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [3:0]         dct_count,
  output logic               pkt_valid,
  input  logic               pkt_ready,
  output logic               overflow,
  output logic               test_has_ended
`ifdef OCI_DCT_DROP_CNT_EN
  ,
  output logic [7:0]         dropped_cnt
`endif
);

  import oci_dct_pkg::*;

  state_e           state_q, state_d;
  logic             end_req_q, end_req_d;
  logic [BUF_W-1:0] out_buf_q, out_buf_d;
  logic [3:0]       out_cnt_q, out_cnt_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             overflow_q, overflow_d;

  logic [BUF_W-1:0] asm_buf;
  logic [3:0]       asm_cnt;
  logic             asm_full;
  logic             out_free, take, wr, drop;

  oci_dct_packer #(
    .ENTRY_W (ENTRY_W),
    .ENTRIES (ENTRIES)
  ) u_packer (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (wr),
    .take_i (take),
    .code_i (te_code),
    .buf_o  (asm_buf),
    .cnt_o  (asm_cnt),
    .full_o (asm_full)
  );

  always_comb begin
    state_d     = state_q;
    end_req_d   = end_req_q;
    out_buf_d   = out_buf_q;
    out_cnt_d   = out_cnt_q;
    pkt_valid_d = pkt_valid_q;
    out_free    = !pkt_valid_q || pkt_ready;
    take        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (test_ending) begin
          state_d   = ST_DRAIN;
          end_req_d = 1'b1;
        end else if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        take = asm_full && out_free;
        if (!enable || test_ending) begin
          state_d   = ST_DRAIN;
          end_req_d = test_ending;
        end
      end
      ST_DRAIN: begin
        take = (asm_cnt != 4'd0) && out_free;
        if ((asm_cnt == 4'd0) && !pkt_valid_q) begin
          state_d = end_req_q ? ST_ENDED : ST_IDLE;
        end
      end
      ST_ENDED: state_d = ST_ENDED;
    endcase

    // Only RUN captures entries; a full assembly still accepts one if it empties this edge.
    wr         = (state_q == ST_RUN) && te_valid && (!asm_full || take);
    drop       = (state_q == ST_RUN) && te_valid && asm_full && !take;
    overflow_d = overflow_q || drop;

    if (take) begin
      out_buf_d   = asm_buf;
      out_cnt_d   = asm_cnt;
      pkt_valid_d = 1'b1;
    end else if (pkt_valid_q && pkt_ready) begin
      out_buf_d   = '0;
      out_cnt_d   = 4'd0;
      pkt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      end_req_q   <= 1'b0;
      out_buf_q   <= '0;
      out_cnt_q   <= 4'd0;
      pkt_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      end_req_q   <= end_req_d;
      out_buf_q   <= out_buf_d;
      out_cnt_q   <= out_cnt_d;
      pkt_valid_q <= pkt_valid_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef OCI_DCT_DROP_CNT_EN
  logic [7:0] dropped_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_q <= 8'd0;
    end else if (drop && (dropped_q != 8'hFF)) begin
      dropped_q <= dropped_q + 8'd1;
    end
  end

  assign dropped_cnt = dropped_q;
`endif

  assign dct_buffer     = out_buf_q;
  assign dct_count      = out_cnt_q;
  assign pkt_valid      = pkt_valid_q;
  assign overflow       = overflow_q;
  assign test_has_ended = (state_q == ST_ENDED);

endmodule

`default_nettype wire

// File: tb/tb_oci_dct_sequencer.sv
// ============================================================================
// Module   : tb_oci_dct_sequencer
// Summary  : Self-checking bench for oci_dct_sequencer; honours OCI_DCT_DROP_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_oci_dct_sequencer;

  localparam int NE = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        te_valid = 1'b0;
  logic [2:0]  te_code = 3'd0;
  logic        test_ending = 1'b0;
  logic        pkt_ready = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic        overflow;
  logic        test_has_ended;
`ifdef OCI_DCT_DROP_CNT_EN
  logic [7:0]  dropped_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  oci_dct_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .te_valid       (te_valid),
    .te_code        (te_code),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .overflow       (overflow),
    .test_has_ended (test_has_ended)
`ifdef OCI_DCT_DROP_CNT_EN
    ,
    .dropped_cnt    (dropped_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending codes plus one output packet slot.
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_ENDED = 3;
  int          m_mode;
  bit          m_end;
  logic [2:0]  m_asm[$];
  bit          m_valid;
  logic [29:0] m_buf;
  int          m_cnt;
  bit          m_ovf;
  int          m_drops;

  function automatic logic [29:0] pack(input logic [2:0] q[$]);
    logic [29:0] r;
    r = '0;
    for (int i = 0; i < q.size(); i++) r[3*i +: 3] = q[i];
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_end = 0; m_asm.delete(); m_valid = 0;
    m_buf = '0; m_cnt = 0; m_ovf = 0; m_drops = 0;
  endtask

  task automatic model_step();
    bit free, take, was_valid;
    int n;
    was_valid = m_valid;
    n = m_asm.size();
    free = !m_valid || pkt_ready;
    take = ((m_mode == M_RUN && n == NE) || (m_mode == M_DRAIN && n > 0)) && free;
    if (take) begin
      m_buf = pack(m_asm); m_cnt = n; m_valid = 1; m_asm.delete();
    end else if (m_valid && pkt_ready) begin
      m_valid = 0;
    end
    if (m_mode == M_RUN && te_valid) begin
      if (n < NE || take) m_asm.push_back(te_code);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    case (m_mode)
      M_IDLE:  if (test_ending) begin m_mode = M_DRAIN; m_end = 1; end
               else if (enable) m_mode = M_RUN;
      M_RUN:   if (!enable || test_ending) begin m_mode = M_DRAIN; m_end = test_ending; end
      M_DRAIN: if (n == 0 && !was_valid) m_mode = m_end ? M_ENDED : M_IDLE;
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("pkt_valid", pkt_valid, m_valid);
    chk("overflow", overflow, m_ovf);
    chk("test_has_ended", test_has_ended, m_mode == M_ENDED);
`ifdef OCI_DCT_DROP_CNT_EN
    chk("dropped_cnt", dropped_cnt, m_drops);
`endif
    if (m_valid) begin
      chk("dct_buffer", dct_buffer, m_buf);
      chk("dct_count", dct_count, m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; te_valid = 0; test_ending = 0; pkt_ready = 0;
    tick();
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_dct_buffer", dct_buffer, 0);
    chk("rst_dct_count", dct_count, 0);
    tick();
    reset = 0;
    tick();
  endtask

  task automatic put(input logic [2:0] c);
    te_valid = 1; te_code = c;
    tick();
    te_valid = 0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (pkt_valid !== 1'b1 && k < 40) begin tick(); k++; end
    chk(name, pkt_valid, 1);
  endtask

  logic [2:0]  codes[21];
  logic [29:0] exp_buf;

  initial begin
    // Ten entries of 001 with output free
    do_reset();
    enable = 1; pkt_ready = 1;
    tick();
    for (int i = 0; i < NE; i++) put(3'b001);
    chk("lat_edge_t", pkt_valid, 0);
    tick();
    chk("lat_edge_t1", pkt_valid, 1);
    chk("a_buffer", dct_buffer, 32'h09249249);
    chk("a_count", dct_count, 10);
    chk("a_overflow", overflow, 0);

    // Partial packet 5,6,7 then end of test
    do_reset();
    enable = 1; pkt_ready = 1;
    tick();
    put(3'd5); put(3'd6); put(3'd7);
    test_ending = 1;
    tick();
    test_ending = 0;
    wait_valid("b_valid");
    chk("b_buffer", dct_buffer, 32'h000001F5);
    chk("b_count", dct_count, 3);
    for (int k = 0; k < 20 && test_has_ended !== 1'b1; k++) tick();
    chk("b_ended", test_has_ended, 1);
    for (int k = 0; k < 3; k++) put(3'd2);
    chk("b_ended_ignores", overflow, 0);

    // Stalled sink: 21 entries, the last one is dropped
    do_reset();
    enable = 1; pkt_ready = 0;
    tick();
    for (int i = 0; i < 21; i++) begin
      codes[i] = 3'($urandom_range(0, 7));
      put(codes[i]);
    end
    exp_buf = '0;
    for (int i = 0; i < NE; i++) exp_buf[3*i +: 3] = codes[i];
    chk("c_valid", pkt_valid, 1);
    chk("c_held_buffer", dct_buffer, exp_buf);
    chk("c_overflow", overflow, 1);
`ifdef OCI_DCT_DROP_CNT_EN
    chk("c_dropped", dropped_cnt, 1);
`endif

    // Handshake, reload and write on the same edge
    do_reset();
    enable = 1; pkt_ready = 0;
    tick();
    for (int i = 0; i < 20; i++) begin
      codes[i] = 3'($urandom_range(0, 7));
      put(codes[i]);
    end
    pkt_ready = 1; te_valid = 1; te_code = 3'd5;
    tick();
    te_valid = 0; pkt_ready = 0;
    exp_buf = '0;
    for (int i = 0; i < NE; i++) exp_buf[3*i +: 3] = codes[NE+i];
    chk("d_valid", pkt_valid, 1);
    chk("d_buffer", dct_buffer, exp_buf);
    chk("d_overflow", overflow, 0);
    enable = 0; pkt_ready = 1;
    tick();
    wait_valid("d_partial_valid");
    chk("d_partial_buffer", dct_buffer, 32'h5);
    chk("d_partial_count", dct_count, 1);

    // Asynchronous reset with a pending packet and four queued entries
    do_reset();
    enable = 1; pkt_ready = 0;
    tick();
    for (int i = 0; i < 14; i++) put(3'($urandom_range(0, 7)));
    chk("e_valid_before", pkt_valid, 1);
    #2;
    reset = 1;
    #1;
    chk("e_async_valid", pkt_valid, 0);
    chk("e_async_buffer", dct_buffer, 0);
    chk("e_async_count", dct_count, 0);
    chk("e_async_overflow", overflow, 0);
    chk("e_async_ended", test_has_ended, 0);
    tick();
    reset = 0;
    tick();

    // Randomised traffic against the model
    do_reset();
    enable = 1;
    for (int c = 0; c < 4000; c++) begin
      te_valid    = ($urandom_range(0, 99) < 60);
      te_code     = 3'($urandom_range(0, 7));
      pkt_ready   = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 15));
      test_ending = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if (test_has_ended && $urandom_range(0, 9) == 0) reset = 1;
      tick();
      reset = 0;
    end
    te_valid = 0; test_ending = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
